// File: rtl/psum_link_net.sv
// psum_link_net: buffered partial-sum network between vertically adjacent PE rows.
// For each row boundary r (0..NUMS_PE_ROW-2) and column c there is one link FIFO.
// Its source is PE (r+1)*COL+c (opsum) and its sink is PE r*COL+c (ipsum).
// When LN_config[r]=1 the FIFOs of that boundary carry the traffic.
// When LN_config[r]=0 the PEs connect combinationally to the GIN/GON.
//
// Ports:
//   clk, rst (async, active low)
//   set_LN / LN_config_in   : load a new link configuration (only while idle)
//   flush                   : synchronous clear of all link FIFOs
//   pe_opsum*, pe_ipsum*    : packed per-PE psum handshakes, slice i = [DATA_SIZE*i +: DATA_SIZE]
//   gin_ipsum*, gon_opsum*  : global input/output network handshakes
//   LN_config, busy, cfg_err: active configuration, any FIFO occupied, sticky reject flag
module psum_link_net #(
    parameter int NUMS_PE_ROW = 6,
    parameter int NUMS_PE_COL = 8,
    parameter int DATA_SIZE   = 32,
    parameter int LINK_DEPTH  = 2
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        set_LN,
    input  logic [NUMS_PE_ROW-2:0]                      LN_config_in,
    input  logic                                        flush,
    input  logic [DATA_SIZE*NUMS_PE_ROW*NUMS_PE_COL-1:0] pe_opsum,
    input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]           pe_opsum_valid,
    output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]           pe_opsum_ready,
    output logic [DATA_SIZE*NUMS_PE_ROW*NUMS_PE_COL-1:0] pe_ipsum,
    output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]           pe_ipsum_valid,
    input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]           pe_ipsum_ready,
    input  logic [DATA_SIZE-1:0]                        gin_ipsum,
    input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]           gin_ipsum_valid,
    output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]           gin_ipsum_ready,
    output logic [DATA_SIZE*NUMS_PE_ROW*NUMS_PE_COL-1:0] gon_opsum,
    output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]           gon_opsum_valid,
    input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]           gon_opsum_ready,
    output logic [NUMS_PE_ROW-2:0]                      LN_config,
    output logic                                        busy,
    output logic                                        cfg_err
);

    localparam int N     = NUMS_PE_ROW * NUMS_PE_COL;
    localparam int NF    = (NUMS_PE_ROW - 1) * NUMS_PE_COL;
    localparam int PTR_W = $clog2(LINK_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [NUMS_PE_ROW-2:0] ln_cfg_q, ln_cfg_d;
    logic                   cfg_err_q, cfg_err_d;

    logic [DATA_SIZE-1:0] mem_q [NF][LINK_DEPTH];
    logic [DATA_SIZE-1:0] mem_d [NF][LINK_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q [NF];
    logic [PTR_W-1:0]     wr_ptr_d [NF];
    logic [PTR_W-1:0]     rd_ptr_q [NF];
    logic [PTR_W-1:0]     rd_ptr_d [NF];
    logic [CNT_W-1:0]     cnt_q [NF];
    logic [CNT_W-1:0]     cnt_d [NF];

    logic [NF-1:0]        fifo_full;
    logic [NF-1:0]        fifo_nempty;
    logic [NF-1:0]        push;
    logic [NF-1:0]        pop;
    logic [DATA_SIZE-1:0] head [NF];

    // Per-FIFO status and handshakes. Full/non-empty come from the count only,
    // so no ready input reaches a ready output through a linked path.
    for (genvar f = 0; f < NF; f++) begin : g_fifo
        localparam int R = f / NUMS_PE_COL;
        assign fifo_full[f]   = (cnt_q[f] == CNT_W'(LINK_DEPTH));
        assign fifo_nempty[f] = (cnt_q[f] != '0);
        assign push[f] = ln_cfg_q[R] & pe_opsum_valid[f + NUMS_PE_COL] & ~fifo_full[f];
        assign pop[f]  = ln_cfg_q[R] & fifo_nempty[f] & pe_ipsum_ready[f];
        assign head[f] = mem_q[f][rd_ptr_q[f]];
    end

    // Per-PE steering. Sink rows are 0..ROW-2, source rows are 1..ROW-1;
    // FIFO index of a sink PE equals the PE index.
    for (genvar i = 0; i < N; i++) begin : g_pe
        localparam int R = i / NUMS_PE_COL;

        if (R < NUMS_PE_ROW - 1) begin : g_sink
            assign pe_ipsum[DATA_SIZE*i +: DATA_SIZE] = ln_cfg_q[R] ? head[i] : gin_ipsum;
            assign pe_ipsum_valid[i]  = ln_cfg_q[R] ? fifo_nempty[i] : gin_ipsum_valid[i];
            assign gin_ipsum_ready[i] = ln_cfg_q[R] ? 1'b0 : pe_ipsum_ready[i];
        end else begin : g_sink_pt
            assign pe_ipsum[DATA_SIZE*i +: DATA_SIZE] = gin_ipsum;
            assign pe_ipsum_valid[i]  = gin_ipsum_valid[i];
            assign gin_ipsum_ready[i] = pe_ipsum_ready[i];
        end

        if (R > 0) begin : g_src
            assign gon_opsum_valid[i] = ln_cfg_q[R-1] ? 1'b0 : pe_opsum_valid[i];
            assign pe_opsum_ready[i]  = ln_cfg_q[R-1] ? ~fifo_full[i - NUMS_PE_COL]
                                                      : gon_opsum_ready[i];
        end else begin : g_src_pt
            assign gon_opsum_valid[i] = pe_opsum_valid[i];
            assign pe_opsum_ready[i]  = gon_opsum_ready[i];
        end
    end

    assign gon_opsum = pe_opsum;
    assign busy      = |fifo_nempty;
    assign LN_config = ln_cfg_q;
    assign cfg_err   = cfg_err_q;

    // Configuration may only change while every link is drained; busy reflects
    // the occupancy before any same-cycle flush takes effect.
    always_comb begin
        ln_cfg_d  = ln_cfg_q;
        cfg_err_d = cfg_err_q;
        if (set_LN) begin
            if (!busy) begin
                ln_cfg_d  = LN_config_in;
                cfg_err_d = 1'b0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        for (int f = 0; f < NF; f++) begin
            if (flush) begin
                wr_ptr_d[f] = '0;
                rd_ptr_d[f] = '0;
                cnt_d[f]    = '0;
            end else begin
                if (push[f]) begin
                    mem_d[f][wr_ptr_q[f]] = pe_opsum[DATA_SIZE*(f + NUMS_PE_COL) +: DATA_SIZE];
                    wr_ptr_d[f] = wr_ptr_q[f] + PTR_W'(1);
                end
                if (pop[f]) begin
                    rd_ptr_d[f] = rd_ptr_q[f] + PTR_W'(1);
                end
                case ({push[f], pop[f]})
                    2'b10:   cnt_d[f] = cnt_q[f] + CNT_W'(1);
                    2'b01:   cnt_d[f] = cnt_q[f] - CNT_W'(1);
                    default: cnt_d[f] = cnt_q[f];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ln_cfg_q  <= '0;
            cfg_err_q <= 1'b0;
            for (int f = 0; f < NF; f++) begin
                wr_ptr_q[f] <= '0;
                rd_ptr_q[f] <= '0;
                cnt_q[f]    <= '0;
                for (int d = 0; d < LINK_DEPTH; d++) begin
                    mem_q[f][d] <= '0;
                end
            end
        end else begin
            ln_cfg_q  <= ln_cfg_d;
            cfg_err_q <= cfg_err_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            mem_q     <= mem_d;
        end
    end

endmodule

// File: tb/tb_psum_link_net.sv
module tb_psum_link_net;

    localparam int ROW = 6;
    localparam int COL = 8;
    localparam int DW  = 32;
    localparam int N   = ROW * COL;

    logic              clk = 1'b0;
    logic              rst;
    logic              set_LN;
    logic [ROW-2:0]    LN_config_in;
    logic              flush;
    logic [DW*N-1:0]   pe_opsum;
    logic [N-1:0]      pe_opsum_valid;
    logic [N-1:0]      pe_opsum_ready;
    logic [DW*N-1:0]   pe_ipsum;
    logic [N-1:0]      pe_ipsum_valid;
    logic [N-1:0]      pe_ipsum_ready;
    logic [DW-1:0]     gin_ipsum;
    logic [N-1:0]      gin_ipsum_valid;
    logic [N-1:0]      gin_ipsum_ready;
    logic [DW*N-1:0]   gon_opsum;
    logic [N-1:0]      gon_opsum_valid;
    logic [N-1:0]      gon_opsum_ready;
    logic [ROW-2:0]    LN_config;
    logic              busy;
    logic              cfg_err;

    psum_link_net #(
        .NUMS_PE_ROW(ROW), .NUMS_PE_COL(COL), .DATA_SIZE(DW), .LINK_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst), .set_LN(set_LN), .LN_config_in(LN_config_in), .flush(flush),
        .pe_opsum(pe_opsum), .pe_opsum_valid(pe_opsum_valid), .pe_opsum_ready(pe_opsum_ready),
        .pe_ipsum(pe_ipsum), .pe_ipsum_valid(pe_ipsum_valid), .pe_ipsum_ready(pe_ipsum_ready),
        .gin_ipsum(gin_ipsum), .gin_ipsum_valid(gin_ipsum_valid), .gin_ipsum_ready(gin_ipsum_ready),
        .gon_opsum(gon_opsum), .gon_opsum_valid(gon_opsum_valid), .gon_opsum_ready(gon_opsum_ready),
        .LN_config(LN_config), .busy(busy), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] sb_q[$];

    typedef struct {
        int          pe;
        logic [31:0] gin;
        logic        gin_v;
        logic        ipsum_rdy;
        logic        opsum_v;
        logic        gon_rdy;
        logic [31:0] opsum;
        logic [31:0] exp_ipsum;
        logic        exp_ipsum_v;
        logic        exp_gin_rdy;
        logic        exp_gon_v;
        logic        exp_opsum_rdy;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        set_LN          = 1'b0;
        LN_config_in    = '0;
        flush           = 1'b0;
        pe_opsum        = '0;
        pe_opsum_valid  = '0;
        pe_ipsum_ready  = '0;
        gin_ipsum       = '0;
        gin_ipsum_valid = '0;
        gon_opsum_ready = '0;
    endtask

    // One clock cycle on link (row1 -> row0, column 0): checks every sink pop
    // against the scoreboard and records every source push before the edge.
    task automatic tick();
        #1;
        if (!flush) begin
            if (pe_ipsum_valid[0] && pe_ipsum_ready[0]) begin
                chk("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) chk("sink0_data", 64'(pe_ipsum[DW-1:0]), 64'(sb_q.pop_front()));
            end
            if (pe_opsum_valid[8] && pe_opsum_ready[8] && LN_config[0]) begin
                sb_q.push_back(pe_opsum[DW*8 +: DW]);
            end
        end
        @(posedge clk);
        if (flush) sb_q.delete();
        #1;
    endtask

    task automatic drive_src(input logic v, input logic [31:0] d);
        pe_opsum_valid[8]     = v;
        pe_opsum[DW*8 +: DW]  = d;
    endtask

    initial begin
        vecs[0] = '{5,  32'h11, 1'b1, 1'b1, 1'b1, 1'b1, 32'hAB, 32'h11, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{0,  32'h22, 1'b1, 1'b0, 1'b0, 1'b1, 32'hCD, 32'h22, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8,  32'h33, 1'b0, 1'b1, 1'b1, 1'b0, 32'hEF, 32'h33, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{47, 32'h44, 1'b1, 1'b1, 1'b1, 1'b1, 32'h12, 32'h44, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{40, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0, 32'h34, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0};

        clear_inputs();
        rst = 1'b0;
        #2;
        chk("rst_ln_config", 64'(LN_config), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cfg_err", 64'(cfg_err), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Passthrough with LN_config=0
        for (int k = 0; k < 5; k++) begin
            clear_inputs();
            gin_ipsum                        = vecs[k].gin;
            gin_ipsum_valid[vecs[k].pe]      = vecs[k].gin_v;
            pe_ipsum_ready[vecs[k].pe]       = vecs[k].ipsum_rdy;
            pe_opsum_valid[vecs[k].pe]       = vecs[k].opsum_v;
            gon_opsum_ready[vecs[k].pe]      = vecs[k].gon_rdy;
            pe_opsum[DW*vecs[k].pe +: DW]    = vecs[k].opsum;
            #1;
            chk("pt_ipsum", 64'(pe_ipsum[DW*vecs[k].pe +: DW]), 64'(vecs[k].exp_ipsum));
            chk("pt_ipsum_v", 64'(pe_ipsum_valid[vecs[k].pe]), 64'(vecs[k].exp_ipsum_v));
            chk("pt_gin_rdy", 64'(gin_ipsum_ready[vecs[k].pe]), 64'(vecs[k].exp_gin_rdy));
            chk("pt_gon_v", 64'(gon_opsum_valid[vecs[k].pe]), 64'(vecs[k].exp_gon_v));
            chk("pt_opsum_rdy", 64'(pe_opsum_ready[vecs[k].pe]), 64'(vecs[k].exp_opsum_rdy));
            chk("pt_gon_data", 64'(gon_opsum[DW*vecs[k].pe +: DW]), 64'(vecs[k].opsum));
        end
        clear_inputs();

        // Link boundary 0
        set_LN = 1'b1;
        LN_config_in = 5'b00001;
        tick();
        set_LN = 1'b0;
        chk("link_cfg", 64'(LN_config), 64'd1);
        chk("link_err", 64'(cfg_err), 64'd0);

        // Stream 0xA,0xB,0xC with sink always ready
        pe_ipsum_ready[0]  = 1'b1;
        gin_ipsum_valid[0] = 1'b1;
        drive_src(1'b1, 32'hA);
        #1;
        chk("no_bypass", 64'(pe_ipsum_valid[0]), 64'd0);
        chk("gin_rdy_linked", 64'(gin_ipsum_ready[0]), 64'd0);
        for (int c = 0; c < 8; c++) begin
            if (c < 3) drive_src(1'b1, 32'hA + 32'(c));
            else drive_src(1'b0, 32'h0);
            #1;
            chk("gon_v8_linked", 64'(gon_opsum_valid[8]), 64'd0);
            if (c >= 1 && c <= 3) chk("sink_valid_lat1", 64'(pe_ipsum_valid[0]), 64'd1);
            tick();
        end
        chk("stream_drained", 64'(sb_q.size()), 64'd0);
        chk("stream_busy", 64'(busy), 64'd0);

        // Full backpressure
        pe_ipsum_ready[0] = 1'b0;
        drive_src(1'b1, 32'h1);
        tick();
        drive_src(1'b1, 32'h2);
        tick();
        drive_src(1'b1, 32'h3);
        #1;
        chk("full_rdy", 64'(pe_opsum_ready[8]), 64'd0);
        chk("full_busy", 64'(busy), 64'd1);
        pe_ipsum_ready[0] = 1'b1;
        #1;
        chk("full_pop_rdy", 64'(pe_opsum_ready[8]), 64'd0);
        tick();
        pe_ipsum_ready[0] = 1'b0;
        drive_src(1'b0, 32'h0);
        #1;
        chk("after_pop_rdy", 64'(pe_opsum_ready[8]), 64'd1);
        chk("after_pop_busy", 64'(busy), 64'd1);
        chk("after_pop_head", 64'(pe_ipsum[DW-1:0]), 64'h2);

        // Rejected configuration while busy
        set_LN = 1'b1;
        LN_config_in = 5'b00000;
        tick();
        set_LN = 1'b0;
        chk("rej_cfg", 64'(LN_config), 64'd1);
        chk("rej_err", 64'(cfg_err), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        set_LN = 1'b1;
        LN_config_in = 5'b00000;
        tick();
        set_LN = 1'b0;
        chk("acc_cfg", 64'(LN_config), 64'd0);
        chk("acc_err", 64'(cfg_err), 64'd0);

        // Flush with simultaneous push, pop and rejected set_LN
        set_LN = 1'b1;
        LN_config_in = 5'b00001;
        tick();
        set_LN = 1'b0;
        drive_src(1'b1, 32'h5);
        tick();
        flush = 1'b1;
        set_LN = 1'b1;
        LN_config_in = 5'b00011;
        drive_src(1'b1, 32'h6);
        pe_ipsum_ready[0] = 1'b1;
        #1;
        chk("fl_push_rdy", 64'(pe_opsum_ready[8]), 64'd1);
        chk("fl_pop_v", 64'(pe_ipsum_valid[0]), 64'd1);
        tick();
        flush = 1'b0;
        set_LN = 1'b0;
        drive_src(1'b0, 32'h0);
        pe_ipsum_ready[0] = 1'b0;
        #1;
        chk("fl_busy", 64'(busy), 64'd0);
        chk("fl_sink_v", 64'(pe_ipsum_valid[0]), 64'd0);
        chk("fl_cfg_kept", 64'(LN_config), 64'd1);
        chk("fl_cfg_err", 64'(cfg_err), 64'd1);
        tick();
        chk("fl_busy_next", 64'(busy), 64'd0);

        // Async reset mid-stream with 2 entries
        drive_src(1'b1, 32'h7);
        tick();
        drive_src(1'b1, 32'h8);
        tick();
        drive_src(1'b0, 32'h0);
        gin_ipsum_valid[0] = 1'b0;
        #1;
        chk("pre_rst_busy", 64'(busy), 64'd1);
        chk("pre_rst_rdy", 64'(pe_opsum_ready[8]), 64'd0);
        rst = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_cfg", 64'(LN_config), 64'd0);
        chk("arst_err", 64'(cfg_err), 64'd0);
        chk("arst_sink_v", 64'(pe_ipsum_valid[0]), 64'd0);
        gin_ipsum_valid[0] = 1'b1;
        #1;
        chk("arst_passthru", 64'(pe_ipsum_valid[0]), 64'd1);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
